// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_pkg
// Description : Shared register-file geometry and the dump-reader state
//               encoding for the MIPS core.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

    localparam int REG_ADDR_W = 3;
    localparam int REG_DATA_W = 32;
    localparam int NUM_REGS   = 8;

    // Dump reader states; explicit 2-bit encoding
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETUP   = 2'd1,
        PRESENT = 2'd2,
        FIN     = 2'd3
    } dump_state_t;

endpackage : mips_pkg
`default_nettype wire

// File: rtl/mips_reg_dump_reader.sv
`default_nettype none
// ============================================================================
// Module      : mips_reg_dump_reader
// Description : Walks every register of the MIPS register file through its
//               combinational read port and streams each captured word out
//               on a valid/ready handshake, with index, last flag and a
//               running XOR checksum of the accepted words.
// Revision    : 1.0 - initial release
// ============================================================================
module mips_reg_dump_reader
    import mips_pkg::*;
#(
    parameter int NUM_REGS  = mips_pkg::NUM_REGS,
    parameter int ADDR_W    = mips_pkg::REG_ADDR_W,
    parameter int DATA_W    = mips_pkg::REG_DATA_W,
    parameter int SKIP_ZERO = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [ADDR_W-1:0] rf_read_reg,
    input  logic [DATA_W-1:0] rf_read_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_index,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] checksum
);

    // Register 0 is hard-wired zero, so it may be left out of the walk
    localparam logic [ADDR_W-1:0] c_first_idx = (SKIP_ZERO != 0) ? ADDR_W'(1) : ADDR_W'(0);
    localparam logic [ADDR_W-1:0] c_last_idx  = ADDR_W'(NUM_REGS - 1);

    dump_state_t       r_state;
    logic [ADDR_W-1:0] w_next_idx;

    // The read address doubles as the walk index; it never passes the last
    // register because the walk terminates on out_last, not on overflow.
    assign w_next_idx = rf_read_reg + 1'b1;

    // Dump FSM: address setup, capture, handshake, completion pulse
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            rf_read_reg <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_index   <= '0;
            out_last    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            checksum    <= '0;
        end else begin
            done <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (start) begin
                        rf_read_reg <= c_first_idx;
                        checksum    <= '0;
                        busy        <= 1'b1;
                        r_state     <= SETUP;
                    end
                end
                SETUP: begin
                    // Address has been stable for a full cycle; snapshot it
                    out_data  <= rf_read_data;
                    out_index <= rf_read_reg;
                    out_last  <= (rf_read_reg == c_last_idx);
                    out_valid <= 1'b1;
                    r_state   <= PRESENT;
                end
                PRESENT: begin
                    // Word is held unchanged for as long as the consumer stalls
                    if (out_ready) begin
                        checksum  <= checksum ^ out_data;
                        out_valid <= 1'b0;
                        if (out_last) begin
                            done    <= 1'b1;
                            r_state <= FIN;
                        end else begin
                            rf_read_reg <= w_next_idx;
                            r_state     <= SETUP;
                        end
                    end
                end
                FIN: begin
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule : mips_reg_dump_reader
`default_nettype wire

// File: tb/tb_mips_reg_dump_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_mips_reg_dump_reader
// Description : Self-checking bench for mips_reg_dump_reader with a register
//               file model, a word scoreboard per DUT and a vector table.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_reg_dump_reader;

    localparam int AW = 3;
    localparam int DW = 32;
    localparam int NR = 8;

    typedef struct {
        logic [DW-1:0] data;
        logic [AW-1:0] index;
        logic          last;
    } word_t;

    typedef struct {
        int            kind;
        int            stall_idx;
        int            stall_len;
        logic [DW-1:0] exp_ck;
        int            exp_done_edge;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          start_a, start_b, ready_a, ready_b;
    logic [AW-1:0] rreg_a, rreg_b, idx_a, idx_b;
    logic [DW-1:0] rdata_a, rdata_b, data_a, data_b, ck_a, ck_b;
    logic          valid_a, valid_b, last_a, last_b;
    logic          busy_a, busy_b, done_a, done_b;

    logic [DW-1:0] rf [NR];
    assign rdata_a = rf[rreg_a];
    assign rdata_b = rf[rreg_b];

    word_t sbq_a[$];
    word_t sbq_b[$];
    int    checks = 0;
    int    errors = 0;
    int    done_cnt_a = 0;
    int    done_cnt_b = 0;
    vec_t  vecs[4];

    mips_reg_dump_reader #(.NUM_REGS(NR), .ADDR_W(AW), .DATA_W(DW), .SKIP_ZERO(0)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a),
        .rf_read_reg(rreg_a), .rf_read_data(rdata_a),
        .out_valid(valid_a), .out_ready(ready_a), .out_data(data_a),
        .out_index(idx_a), .out_last(last_a),
        .busy(busy_a), .done(done_a), .checksum(ck_a)
    );

    mips_reg_dump_reader #(.NUM_REGS(NR), .ADDR_W(AW), .DATA_W(DW), .SKIP_ZERO(1)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b),
        .rf_read_reg(rreg_b), .rf_read_data(rdata_b),
        .out_valid(valid_b), .out_ready(ready_b), .out_data(data_b),
        .out_index(idx_b), .out_last(last_b),
        .busy(busy_b), .done(done_b), .checksum(ck_b)
    );

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Scoreboard monitors: a presented word must match the queue head; pop on handshake
    always @(negedge clk) begin
        if (rst_n && valid_a) begin
            if (sbq_a.size() == 0) begin
                checks++; errors++;
                $display("FAIL a_unexpected_word: got index %0d data 0x%08h, expected no word", idx_a, data_a);
            end else begin
                check("a_data",  data_a, sbq_a[0].data);
                check("a_index", DW'(idx_a), DW'(sbq_a[0].index));
                check("a_last",  DW'(last_a), DW'(sbq_a[0].last));
                if (ready_a) void'(sbq_a.pop_front());
            end
        end
        if (rst_n && valid_b) begin
            if (sbq_b.size() == 0) begin
                checks++; errors++;
                $display("FAIL b_unexpected_word: got index %0d data 0x%08h, expected no word", idx_b, data_b);
            end else begin
                check("b_data",  data_b, sbq_b[0].data);
                check("b_index", DW'(idx_b), DW'(sbq_b[0].index));
                check("b_last",  DW'(last_b), DW'(sbq_b[0].last));
                if (ready_b) void'(sbq_b.pop_front());
            end
        end
        if (rst_n && done_a) done_cnt_a++;
        if (rst_n && done_b) done_cnt_b++;
    end

    task automatic fill(input int kind);
        rf[0] = '0;
        for (int i = 1; i < NR; i++) begin
            case (kind)
                0:       rf[i] = 32'd1 << i;
                1:       rf[i] = 32'hA5A5_0000 | i;
                default: rf[i] = 32'hFFFF_FFFF;
            endcase
        end
    endtask

    // One dump; edge 0 is the edge after which start is driven high
    task automatic run_dump(input bit sel, input int first, input int stall_idx, input int stall_len,
                            input bit wr_mid, input bit restart, input int exp_first_valid,
                            input int exp_done_edge, input logic [DW-1:0] exp_ck, input string tag);
        int            e, first_valid, done_edge, stall_left, dc0;
        bit            wrote, v, dn;
        logic [AW-1:0] ix;
        word_t         w;
        @(posedge clk); #1;
        for (int i = first; i < NR; i++) begin
            w.data  = (wr_mid && i == 5) ? 32'hDEAD_BEEF : rf[i];
            w.index = AW'(i);
            w.last  = (i == NR - 1);
            if (sel) sbq_b.push_back(w); else sbq_a.push_back(w);
        end
        dc0 = sel ? done_cnt_b : done_cnt_a;
        if (sel) start_b = 1'b1; else start_a = 1'b1;
        e = 0; first_valid = -1; done_edge = -1; stall_left = stall_len; wrote = 1'b0;
        while (done_edge < 0 && e < 200) begin
            @(posedge clk); e++; #1;
            if (sel) start_b = restart && (e == 5 || e == 9);
            else     start_a = restart && (e == 5 || e == 9);
            v  = sel ? valid_b : valid_a;
            ix = sel ? idx_b : idx_a;
            dn = sel ? done_b : done_a;
            if (v && first_valid < 0) first_valid = e;
            if (v && int'(ix) == stall_idx && stall_left > 0) begin
                stall_left--;
                if (sel) ready_b = 1'b0; else ready_a = 1'b0;
            end else begin
                if (sel) ready_b = 1'b1; else ready_a = 1'b1;
            end
            if (wr_mid && !wrote && v && ix == 3'd2) begin
                rf[5] = 32'hDEAD_BEEF;
                rf[1] = 32'h1234_5678;
                wrote = 1'b1;
            end
            if (dn) done_edge = e;
        end
        check({tag, "_first_valid_edge"}, DW'(first_valid), DW'(exp_first_valid));
        check({tag, "_done_edge"}, DW'(done_edge), DW'(exp_done_edge));
        check({tag, "_checksum"}, sel ? ck_b : ck_a, exp_ck);
        check({tag, "_words_left"}, DW'(sel ? sbq_b.size() : sbq_a.size()), 32'd0);
        @(posedge clk); #1;
        check({tag, "_done_pulses"}, DW'((sel ? done_cnt_b : done_cnt_a) - dc0), 32'd1);
        check({tag, "_done_after_fin"}, DW'(sel ? done_b : done_a), 32'd0);
        check({tag, "_busy_after_fin"}, DW'(sel ? busy_b : busy_a), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check({tag, "_idle_busy"}, DW'(sel ? busy_b : busy_a), 32'd0);
        check({tag, "_idle_valid"}, DW'(sel ? valid_b : valid_a), 32'd0);
        check({tag, "_checksum_held"}, sel ? ck_b : ck_a, exp_ck);
    endtask

    task automatic check_zero_a(input string tag);
        check({tag, "_rf_read_reg"}, DW'(rreg_a), 32'd0);
        check({tag, "_out_data"},    data_a, 32'd0);
        check({tag, "_out_index"},   DW'(idx_a), 32'd0);
        check({tag, "_checksum"},    ck_a, 32'd0);
        check({tag, "_out_valid"},   DW'(valid_a), 32'd0);
        check({tag, "_out_last"},    DW'(last_a), 32'd0);
        check({tag, "_busy"},        DW'(busy_a), 32'd0);
        check({tag, "_done"},        DW'(done_a), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int dc0, n;
        vecs[0] = '{kind: 0, stall_idx: -1, stall_len: 0, exp_ck: 32'h0000_00FE, exp_done_edge: 17};
        vecs[1] = '{kind: 0, stall_idx:  2, stall_len: 3, exp_ck: 32'h0000_00FE, exp_done_edge: 20};
        vecs[2] = '{kind: 1, stall_idx:  7, stall_len: 5, exp_ck: 32'hA5A5_0000, exp_done_edge: 22};
        vecs[3] = '{kind: 2, stall_idx:  0, stall_len: 1, exp_ck: 32'hFFFF_FFFF, exp_done_edge: 18};

        rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; ready_a = 1'b1; ready_b = 1'b1;
        fill(0);
        repeat (2) @(posedge clk);
        #1;
        check_zero_a("reset");
        check("reset_b_busy", DW'(busy_b), 32'd0);
        rst_n = 1'b1;

        for (int k = 0; k < 4; k++) begin
            fill(vecs[k].kind);
            run_dump(1'b0, 0, vecs[k].stall_idx, vecs[k].stall_len, 1'b0, 1'b0,
                     2, vecs[k].exp_done_edge, vecs[k].exp_ck, $sformatf("vec%0d", k));
        end

        // Register 0 skipped
        fill(0);
        run_dump(1'b1, 1, -1, 0, 1'b0, 1'b0, 2, 15, 32'h0000_00FE, "skip0");

        // Writes during the dump: reg5 not yet read, reg1 already captured
        fill(0);
        run_dump(1'b0, 0, -1, 0, 1'b1, 1'b0, 2, 17, 32'hDEAD_BE31, "coherence");

        // start pulses while busy are ignored
        fill(0);
        run_dump(1'b0, 0, -1, 0, 1'b0, 1'b1, 2, 17, 32'h0000_00FE, "restart_ignored");

        // Reset while index 4 is presented
        fill(0);
        @(posedge clk); #1;
        for (int i = 0; i < NR; i++) sbq_a.push_back('{data: rf[i], index: AW'(i), last: (i == NR - 1)});
        start_a = 1'b1;
        n = 0;
        do begin
            @(posedge clk); #1;
            start_a = 1'b0;
            n++;
        end while (!(valid_a && idx_a == 3'd4) && n < 100);
        check("midreset_reached_idx4", DW'(valid_a && idx_a == 3'd4), 32'd1);
        dc0 = done_cnt_a;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check_zero_a("midreset");
        sbq_a.delete();
        repeat (4) @(posedge clk);
        #1;
        check("midreset_no_done", DW'(done_cnt_a - dc0), 32'd0);
        check("midreset_idle", DW'(busy_a), 32'd0);
        run_dump(1'b0, 0, -1, 0, 1'b0, 1'b0, 2, 17, 32'h0000_00FE, "after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_mips_reg_dump_reader
`default_nettype wire
